mem_port_arbiter: RTL

- Shares one single-ported memory bus between instruction fetch (IF) and the MEM-stage load/store unit of the 5-stage pipeline.
- Sequences bus transactions and buffers the fetched instruction and the load data.
- Merges its own wait requirements with the ID/EX stall requests into the 6-bit pipeline stall vector that drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- stall[n]=1 with stall[n+1]=0 means the register after stage n loads a bubble.

---
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory bus between instruction fetch and the
//   MEM-stage load/store unit. One bus transaction runs at a time; its result
//   is buffered (inst_o / d_rdata_o) and held until the pipeline register that
//   consumes it advances. The block also merges its own wait needs with the
//   ID/EX stall requests into the 6-bit pipeline stall vector.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   pc_i, pc_ce_i        fetch address and fetch enable
//   inst_o               buffered fetched instruction (to IF/ID)
//   d_req_i, d_we_i,
//   d_addr_i, d_wdata_i,
//   d_sel_i              MEM-stage load/store request
//   d_rdata_o            buffered load data
//   stallreq_id_i        ID load-use stall request
//   stallreq_ex_i        EX multi-cycle stall request
//   flush_i              exception flush
//   bus_*                registered memory bus master signals; bus_ack_i and
//                        bus_rdata_i are only looked at while bus_cyc_o=1
//   stall_o              [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   bus_err_o            one-cycle pulse when a transaction times out
//
// Handshake: a bus transaction is open while bus_cyc_o=1; it closes on the
// first cycle where bus_ack_i=1 (data taken from bus_rdata_i that cycle), or
// when TIMEOUT cycles pass without ack, in which case it completes with zero
// data. A buffered result is "valid" while its done flag is set and is
// consumed on the edge where the receiving pipeline register is not stalled.

module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_ce_i,
  output logic [31:0] inst_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_sel_i,
  output logic [31:0] d_rdata_o,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [5:0]  stall_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             i_done;
  logic             d_done;
  logic             discard;

  logic             busy;
  logic             timeout;
  logic             done;
  logic [31:0]      done_data;
  logic             start_d;
  logic             start_i;

  // busy coincides with bus_cyc_o, so an ack outside a transaction is ignored
  assign busy      = (state != IDLE);
  assign timeout   = busy & ~bus_ack_i & (cnt == CNT_W'(TIMEOUT - 1));
  assign done      = busy & (bus_ack_i | timeout);
  assign done_data = bus_ack_i ? bus_rdata_i : 32'h0;

  // Data access wins when both sides are waiting
  assign start_d = (state == IDLE) & d_req_i & ~d_done;
  assign start_i = (state == IDLE) & ~start_d & pc_ce_i & ~i_done & ~flush_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_d) begin
          state_next = DBUS;
        end else if (start_i) begin
          state_next = IBUS;
        end
      end
      IBUS, DBUS: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs: stall vector and timeout pulse.
  // Each request stalls a prefix of the pipeline, so the merged vector is
  // simply the OR of the prefix masks.
  always_comb begin
    stall_o   = 6'b000000;
    bus_err_o = 1'b0;
    if (!rst) begin
      bus_err_o = timeout;
      if (!flush_i) begin
        if (d_req_i & ~d_done) begin
          stall_o = stall_o | 6'b011111;
        end
        if (stallreq_ex_i) begin
          stall_o = stall_o | 6'b001111;
        end
        if (stallreq_id_i) begin
          stall_o = stall_o | 6'b000111;
        end
        if (pc_ce_i & ~i_done) begin
          stall_o = stall_o | 6'b000011;
        end
      end
    end
  end

  // Bus registers, timeout counter and result buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_sel_o   <= 4'h0;
      inst_o      <= 32'h0;
      d_rdata_o   <= 32'h0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (busy && !done) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (start_d) begin
        bus_cyc_o   <= 1'b1;
        bus_we_o    <= d_we_i;
        bus_addr_o  <= d_addr_i;
        bus_wdata_o <= d_wdata_i;
        bus_sel_o   <= d_sel_i;
      end else if (start_i) begin
        bus_cyc_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_addr_o  <= pc_i;
        bus_wdata_o <= 32'h0;
        bus_sel_o   <= 4'hF;
      end else if (done) begin
        bus_cyc_o   <= 1'b0;
        bus_we_o    <= 1'b0;
        bus_addr_o  <= 32'h0;
        bus_wdata_o <= 32'h0;
        bus_sel_o   <= 4'h0;
      end

      // A fetch that was in flight when a flush arrived (including a flush
      // on the completion cycle itself) belongs to the squashed path and is
      // dropped instead of being presented to IF/ID.
      if (state == IBUS && done) begin
        discard <= 1'b0;
        if (discard || flush_i) begin
          i_done <= 1'b0;
        end else begin
          inst_o <= done_data;
          i_done <= 1'b1;
        end
      end else begin
        if (!stall_o[1]) begin
          i_done <= 1'b0;
        end
        if (state == IBUS && flush_i) begin
          discard <= 1'b1;
        end
      end

      if (state == DBUS && done) begin
        d_done <= 1'b1;
        if (!bus_we_o) begin
          d_rdata_o <= done_data;
        end
      end else if (!stall_o[4]) begin
        d_done <= 1'b0;
      end
    end
  end

endmodule
